// File: rtl/mantissa_pkg.sv
// -----------------------------------------------------------------------------
// mantissa_pkg
// Shared definitions for the mantissa divider:
//   - DEFAULT_WIDTH : stored fraction width (implicit leading 1 not counted)
//   - state_t and ST_* : divider FSM state encoding
// No ports; imported by mantissa_divider and mantissa_div_step.
// -----------------------------------------------------------------------------
package mantissa_pkg;

    // Single-precision fraction width.
    localparam int DEFAULT_WIDTH = 23;

    // FSM state encoding. Kept as plain 2-bit constants so the encoding is
    // visible in waveforms and portable to older tool flows.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of restoring-division iterations for a given fraction width:
    // one integer quotient bit plus WIDTH+1 fraction bits.
    function automatic int div_iterations(input int width);
        return width + 2;
    endfunction

endpackage : mantissa_pkg

// File: rtl/mantissa_div_step.sv
// -----------------------------------------------------------------------------
// mantissa_div_step
// One combinational restoring-division step.
//   rem      in  : current partial remainder R (WIDTH+2 bits)
//   div      in  : divisor D = {0, 1, y}       (WIDTH+2 bits)
//   rem_next out : (R - D) << 1 when R >= D, else R << 1
//   qbit     out : 1 when R >= D
// The caller keeps R < 2*D, so the left shift never loses a set bit.
// -----------------------------------------------------------------------------
module mantissa_div_step
    import mantissa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH+1:0] rem,
    input  logic [WIDTH+1:0] div,
    output logic [WIDTH+1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH+1:0] diff;
    logic             ge;

    always_comb begin
        ge   = (rem >= div);
        diff = rem - div;
        qbit = ge;
        // Restore by simply not using the difference when R < D.
        rem_next = ge ? (diff << 1) : (rem << 1);
    end

endmodule : mantissa_div_step

// File: rtl/mantissa_divider.sv
// -----------------------------------------------------------------------------
// mantissa_divider
// Iterative restoring divider for normalized mantissas: computes
// (1.x) / (1.y) one quotient bit per clock, truncating, then normalizes the
// quotient to a 1.f form.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   in_valid     in   operand pair present
//   in_ready     out  divider idle, can accept operands
//   mantissa_1   in   dividend fraction x (value 1.x)
//   mantissa_2   in   divisor fraction y  (value 1.y)
//   out_valid    out  result present (held until out_ready)
//   out_ready    in   consumer takes the result
//   mantissa_out out  normalized quotient fraction
//   shift        out  2'b01 if quotient >= 1, 2'b00 if quotient < 1
//   inexact      out  discarded quotient bits / remainder nonzero
//
// Timing: operands accepted on the edge where in_valid && in_ready; the
// result appears WIDTH+2 clocks later and stays until out_ready is seen.
// -----------------------------------------------------------------------------
module mantissa_divider
    import mantissa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mantissa_1,
    input  logic [WIDTH-1:0] mantissa_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mantissa_out,
    output logic [1:0]       shift,
    output logic             inexact
);

    localparam int ITERS = div_iterations(WIDTH);
    localparam int CW    = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH+1:0] rem_reg;
    logic [WIDTH+1:0] div_reg;
    logic [WIDTH+1:0] quo_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] mant_reg;
    logic [1:0]       shift_reg;
    logic             inexact_reg;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    logic [WIDTH+1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH+1:0] quo_next;
    logic             last_step;
    logic             accept;

    logic             norm_int;
    logic [WIDTH-1:0] norm_mant;
    logic             norm_inexact;

    mantissa_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .div      (div_reg),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    always_comb begin
        accept    = (state_reg == ST_IDLE) && in_valid;
        last_step = (state_reg == ST_RUN) && (cnt_reg == LAST_ITER);

        // Quotient shifts in from the LSB; after ITERS steps the first bit
        // produced (the integer bit) sits in the MSB.
        quo_next = (quo_reg << 1) | {{(WIDTH+1){1'b0}}, step_qbit};

        // Normalization is evaluated on the final step's values so the
        // registered result is ready the same edge the FSM enters DONE.
        // For a quotient < 1 the next bit down is guaranteed set, so the
        // lower window is already normalized.
        norm_int     = quo_next[WIDTH+1];
        norm_mant    = norm_int ? quo_next[WIDTH:1] : quo_next[WIDTH-1:0];
        // The remainder after the final step is < D, so its shifted copy
        // is nonzero exactly when the unshifted one is.
        norm_inexact = (|step_rem) | (norm_int & quo_next[0]);
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rem_reg     <= '0;
            div_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            mant_reg    <= '0;
            shift_reg   <= 2'b00;
            inexact_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                rem_reg <= {2'b01, mantissa_1};
                div_reg <= {2'b01, mantissa_2};
                quo_reg <= '0;
                cnt_reg <= '0;
            end else if (state_reg == ST_RUN) begin
                rem_reg <= step_rem;
                quo_reg <= quo_next;
                cnt_reg <= cnt_reg + CW'(1);
            end

            // Result registers only change on the final iteration, which
            // keeps them stable for the whole DONE back-pressure window.
            if (last_step) begin
                mant_reg    <= norm_mant;
                shift_reg   <= {1'b0, norm_int};
                inexact_reg <= norm_inexact;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = (state_reg == ST_IDLE);
    assign out_valid    = (state_reg == ST_DONE);
    assign mantissa_out = mant_reg;
    assign shift        = shift_reg;
    assign inexact      = inexact_reg;

endmodule : mantissa_divider

// File: tb/tb_mantissa_divider.sv
// -----------------------------------------------------------------------------
// tb_mantissa_divider
// Directed checks of the mantissa divider: reset state, hand-computed
// quotients, latency, back-pressure hold, handoff timing, mid-operation
// reset, plus a short run of random operands against an integer-division
// reference.
// -----------------------------------------------------------------------------
module tb_mantissa_divider;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] mout;
    logic [1:0]   shift;
    logic         inexact;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mantissa_divider #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mantissa_1   (m1),
        .mantissa_2   (m2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mantissa_out (mout),
        .shift        (shift),
        .inexact      (inexact)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor(2^(W+1) * (1.x)/(1.y)) by plain integer division.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] m, output logic [1:0] s,
                         output logic inx);
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] q;
        logic [63:0] r;
        num = (64'(x) | (64'd1 << W)) << (W + 1);
        den = 64'(y) | (64'd1 << W);
        q   = num / den;
        r   = num % den;
        if (q[W+1]) begin
            m   = q[W:1];
            s   = 2'b01;
            inx = (r != 0) || q[0];
        end else begin
            m   = q[W-1:0];
            s   = 2'b00;
            inx = (r != 0);
        end
    endtask

    // One full transaction: optional idle gap, accept, garbage on the input
    // side while busy, latency check, back-pressure hold, handshake.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ex_m, input logic [1:0] ex_s,
                          input logic ex_i, input int pre, input int hold);
        int n;
        repeat (pre) tick();
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", in_ready, 1'b1);
        m1       = x;
        m2       = y;
        in_valid = 1'b1;
        tick();
        // Busy: inputs must be ignored even with in_valid held high.
        m1 = ~x;
        m2 = W'($urandom);
        check("busy_ready", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, 25);
        check("mant", mout, ex_m);
        check("shift", shift, ex_s);
        check("inexact", inexact, ex_i);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
            check("hold_mant", mout, ex_m);
            check("hold_shift", shift, ex_s);
            check("hold_inexact", inexact, ex_i);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", out_valid, 1'b0);
        check("post_ready", in_ready, 1'b1);
        $display("[TB] op x=%06h y=%06h -> mant=%06h shift=%0b inexact=%0b cycles=%0d",
                 x, y, mout, shift, inexact, n);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] em;
        logic [1:0]   es;
        logic         ei;
        logic         seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m1        = '0;
        m2        = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_mant", mout, 0);
        check("rst_shift", shift, 2'b00);
        check("rst_inexact", inexact, 1'b0);

        // Hand-computed directed vectors.
        run_op(23'h000000, 23'h000000, 23'h000000, 2'b01, 1'b0, 0, 0);  // 1/1
        run_op(23'h000000, 23'h400000, 23'h2AAAAA, 2'b00, 1'b1, 1, 0);  // 1/1.5
        run_op(23'h400000, 23'h000000, 23'h400000, 2'b01, 1'b0, 0, 0);  // 1.5/1
        run_op(23'h7FFFFF, 23'h000000, 23'h7FFFFF, 2'b01, 1'b0, 0, 0);  // max/1
        run_op(23'h000000, 23'h7FFFFF, 23'h000000, 2'b00, 1'b1, 2, 0);  // just over 0.5
        run_op(23'h123456, 23'h123456, 23'h000000, 2'b01, 1'b0, 0, 0);  // x == y
        run_op(23'h7FFFFF, 23'h7FFFFF, 23'h000000, 2'b01, 1'b0, 0, 0);  // x == y, max
        run_op(23'h000000, 23'h200000, 23'h4CCCCC, 2'b00, 1'b1, 0, 0);  // 1/1.25 = 0.8
        // Back-pressure: hold out_ready low for 10 cycles.
        run_op(23'h000000, 23'h400000, 23'h2AAAAA, 2'b00, 1'b1, 0, 10);

        // Reset at RUN iteration 10: no result pulse, outputs cleared.
        m1       = '0;
        m2       = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_mant", mout, 0);
        check("mid_rst_shift", shift, 2'b00);
        check("mid_rst_inexact", inexact, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_valid", seen, 1'b0);
        run_op(23'h400000, 23'h000000, 23'h400000, 2'b01, 1'b0, 0, 0);

        // Reset while DONE is waiting for out_ready.
        m1       = 23'h000000;
        m2       = 23'h400000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (25) tick();
        check("done_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("done_rst_valid", out_valid, 1'b0);
        check("done_rst_mant", mout, 0);
        check("done_rst_inexact", inexact, 1'b0);
        run_op(23'h7FFFFF, 23'h000000, 23'h7FFFFF, 2'b01, 1'b0, 0, 0);

        // Random operands with random idle gaps and back-pressure.
        for (int k = 0; k < 150; k++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            model(rx, ry, em, es, ei);
            run_op(rx, ry, em, es, ei, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule : tb_mantissa_divider
